// File: rtl/qspi_pkg.sv
// qspi_pkg: opcodes, FSM state encoding and status-register bit positions
// shared by the QSPI slave and master.
package qspi_pkg;

  localparam logic [7:0] OP_PP    = 8'h02;
  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_WRDI  = 8'h04;
  localparam logic [7:0] OP_RDSR1 = 8'h05;
  localparam logic [7:0] OP_WREN  = 8'h06;
  localparam logic [7:0] OP_QPP   = 8'h32;
  localparam logic [7:0] OP_QOR   = 8'h6B;
  localparam logic [7:0] OP_RDID  = 8'h9F;

  // Status register 1 bit positions
  localparam int unsigned SR_WIP = 0;
  localparam int unsigned SR_WEL = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_RDATA,
    ST_WDATA,
    ST_IGNORE
  } qspi_state_e;

endpackage

// File: rtl/qspi_sync_edge.sv
// qspi_sync_edge: multi-flop synchronizer for one asynchronous input plus
// rising/falling edge detection in the clk_i domain.
module qspi_sync_edge #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Shift the raw input through the synchronizer and remember the last level
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= STAGES'({sync_q, d_i});
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign rise_o = sync_q[STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/qspi_slave.sv
// qspi_slave: SPI mode-0 slave with a host-accessible byte buffer.
// Commands: READ 0x03, PP 0x02, RDID 0x9F, RDSR1 0x05, WREN 0x06, WRDI 0x04.
// Define QSPI_SLAVE_QUAD_EN to add QOR 0x6B and QPP 0x32.
module qspi_slave
  import qspi_pkg::*;
#(
  parameter int unsigned MEM_BYTES   = 64,
  parameter logic [23:0] JEDEC_ID    = 24'h010219,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        write_i,
  input  logic [3:0]  data_be_i,
  input  logic [7:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  input  logic        sclk_i,
  input  logic        cs_ni,
  input  logic [3:0]  io_i,
  output logic [3:0]  io_o,
  output logic [3:0]  io_oe
);

  localparam int unsigned AW = $clog2(MEM_BYTES);

  logic [7:0]    mem_q [MEM_BYTES];
  logic [AW-1:0] host_idx [4];

  qspi_state_e   state_q, state_d;
  logic [4:0]    bitcnt_q, bitcnt_d;
  logic [6:0]    shift_q, shift_d;
  logic [7:0]    cmd_q, cmd_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [1:0]    idx_q, idx_d;
  logic          wel_q, wel_d;
  logic [3:0]    io_o_q, io_o_d;
  logic [7:0]    tx_q, tx_d;
  logic          quad_q, quad_d;

  logic          sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [3:0]    io_sync_q [SYNC_STAGES];
  logic [3:0]    io_s;
  logic [7:0]    shift_in, fetch_byte, out_byte, status;
  logic          last_bit, spi_we;
  logic [7:0]    spi_wbyte;
  logic          unused_addr;

  qspi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (sclk_i),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  qspi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (cs_ni),
    .rise_o (cs_rise),
    .fall_o (cs_fall)
  );

  // Data lines use the same depth as sclk so a detected edge sees aligned data
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < SYNC_STAGES; i++) io_sync_q[i] <= '0;
    end else begin
      io_sync_q[0] <= io_i;
      for (int i = 1; i < SYNC_STAGES; i++) io_sync_q[i] <= io_sync_q[i-1];
    end
  end

  assign io_s        = io_sync_q[SYNC_STAGES-1];
  assign unused_addr = ^addr_i;
`ifndef QSPI_SLAVE_QUAD_EN
  logic unused_io;
  assign unused_io = ^io_s[3:1];
`endif

  // Source byte for the read stream: JEDEC ID rotation, status, or buffer
  always_comb begin
    status         = '0;
    status[SR_WEL] = wel_q;
    status[SR_WIP] = 1'b0;
    case (cmd_q)
      OP_RDID: begin
        case (idx_q)
          2'd0:    fetch_byte = JEDEC_ID[23:16];
          2'd1:    fetch_byte = JEDEC_ID[15:8];
          default: fetch_byte = JEDEC_ID[7:0];
        endcase
      end
      OP_RDSR1: fetch_byte = status;
      default:  fetch_byte = mem_q[addr_q];
    endcase
  end

  // Protocol FSM: next state, counters, shift registers and SPI write strobe
  always_comb begin
    state_d   = state_q;
    bitcnt_d  = bitcnt_q;
    shift_d   = shift_q;
    cmd_d     = cmd_q;
    addr_d    = addr_q;
    idx_d     = idx_q;
    wel_d     = wel_q;
    io_o_d    = io_o_q;
    tx_d      = tx_q;
    quad_d    = quad_q;
    spi_we    = 1'b0;
    spi_wbyte = 8'h00;
    shift_in  = {shift_q, io_s[0]};
    out_byte  = tx_q;
    last_bit  = 1'b0;
    if (cs_rise) begin
      // Deselect ends every transaction; write-enable latch updates here
      state_d  = ST_IDLE;
      bitcnt_d = '0;
      io_o_d   = '0;
      cmd_d    = '0;
      quad_d   = 1'b0;
      case (cmd_q)
        OP_WREN:         wel_d = 1'b1;
        OP_WRDI, OP_PP:  wel_d = 1'b0;
`ifdef QSPI_SLAVE_QUAD_EN
        OP_QPP:          wel_d = 1'b0;
`endif
        default: ;
      endcase
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cs_fall) begin
            state_d  = ST_CMD;
            bitcnt_d = '0;
            cmd_d    = '0;
            quad_d   = 1'b0;
          end
        end
        ST_CMD: begin
          if (sclk_rise) begin
            shift_d  = {shift_q[5:0], io_s[0]};
            bitcnt_d = bitcnt_q + 5'd1;
            if (bitcnt_q == 5'd7) begin
              cmd_d    = shift_in;
              bitcnt_d = '0;
              idx_d    = '0;
              case (shift_in)
                OP_READ:           state_d = ST_ADDR;
                OP_PP:             state_d = wel_q ? ST_ADDR : ST_IGNORE;
                OP_RDID, OP_RDSR1: state_d = ST_RDATA;
`ifdef QSPI_SLAVE_QUAD_EN
                OP_QOR: begin
                  state_d = ST_ADDR;
                  quad_d  = 1'b1;
                end
                OP_QPP: begin
                  state_d = wel_q ? ST_ADDR : ST_IGNORE;
                  quad_d  = 1'b1;
                end
`endif
                default:           state_d = ST_IGNORE;
              endcase
            end
          end
        end
        ST_ADDR: begin
          if (sclk_rise) begin
            shift_d  = {shift_q[5:0], io_s[0]};
            bitcnt_d = bitcnt_q + 5'd1;
            if (bitcnt_q == 5'd23) begin
              addr_d   = shift_in[AW-1:0];
              bitcnt_d = '0;
              case (cmd_q)
                OP_READ: state_d = ST_RDATA;
                OP_PP:   state_d = ST_WDATA;
`ifdef QSPI_SLAVE_QUAD_EN
                OP_QOR:  state_d = ST_DUMMY;
                OP_QPP:  state_d = ST_WDATA;
`endif
                default: state_d = ST_IGNORE;
              endcase
            end
          end
        end
        ST_DUMMY: begin
          if (sclk_rise) begin
            bitcnt_d = bitcnt_q + 5'd1;
            if (bitcnt_q == 5'd7) begin
              bitcnt_d = '0;
              state_d  = ST_RDATA;
            end
          end
        end
        ST_RDATA: begin
          // Master samples on the rising edge, so present data after each fall
          if (sclk_fall) begin
            if (bitcnt_q == 5'd0) out_byte = fetch_byte;
`ifdef QSPI_SLAVE_QUAD_EN
            if (quad_q) begin
              io_o_d   = out_byte[7:4];
              tx_d     = {out_byte[3:0], 4'h0};
              last_bit = (bitcnt_q == 5'd1);
            end else
`endif
            begin
              io_o_d   = {2'b00, out_byte[7], 1'b0};
              tx_d     = {out_byte[6:0], 1'b0};
              last_bit = (bitcnt_q == 5'd7);
            end
            bitcnt_d = bitcnt_q + 5'd1;
            if (last_bit) begin
              bitcnt_d = '0;
              addr_d   = addr_q + 1'b1;
              idx_d    = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
            end
          end
        end
        ST_WDATA: begin
          if (sclk_rise) begin
`ifdef QSPI_SLAVE_QUAD_EN
            if (quad_q) begin
              shift_d   = {shift_q[2:0], io_s};
              spi_wbyte = {shift_q[3:0], io_s};
              last_bit  = (bitcnt_q == 5'd1);
            end else
`endif
            begin
              shift_d   = {shift_q[5:0], io_s[0]};
              spi_wbyte = shift_in;
              last_bit  = (bitcnt_q == 5'd7);
            end
            bitcnt_d = bitcnt_q + 5'd1;
            if (last_bit) begin
              spi_we   = 1'b1;
              bitcnt_d = '0;
              addr_d   = addr_q + 1'b1;
            end
          end
        end
        ST_IGNORE: ;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // Control state with synchronous reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      bitcnt_q <= '0;
      cmd_q    <= '0;
      addr_q   <= '0;
      idx_q    <= '0;
      wel_q    <= 1'b0;
      io_o_q   <= '0;
      quad_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      cmd_q    <= cmd_d;
      addr_q   <= addr_d;
      idx_q    <= idx_d;
      wel_q    <= wel_d;
      io_o_q   <= io_o_d;
      quad_q   <= quad_d;
    end
  end

  // Shift data registers carry no reset
  always_ff @(posedge clk_i) begin
    shift_q <= shift_d;
    tx_q    <= tx_d;
  end

  // Host lane addresses, wrapping within the buffer
  always_comb begin
    for (int b = 0; b < 4; b++) host_idx[b] = addr_i[AW-1:0] + AW'(b);
  end

  // Buffer writes: host lanes first, an SPI commit to the same byte overrides
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (write_i && data_be_i[b] && !(spi_we && (host_idx[b] == addr_q)))
        mem_q[host_idx[b]] <= wdata_i[8*b +: 8];
    end
    if (spi_we) mem_q[addr_q] <= spi_wbyte;
  end

  // Combinational host read, unselected lanes forced to zero
  always_comb begin
    rdata_o = '0;
    for (int b = 0; b < 4; b++) begin
      if (data_be_i[b]) rdata_o[8*b +: 8] = mem_q[host_idx[b]];
    end
  end

`ifdef QSPI_SLAVE_QUAD_EN
  assign io_oe = (state_q == ST_RDATA) ? (quad_q ? 4'b1111 : 4'b0010) : 4'b0000;
`else
  assign io_oe = (state_q == ST_RDATA) ? 4'b0010 : 4'b0000;
`endif
  assign io_o  = io_o_q;

endmodule

// File: tb/tb_qspi_slave.sv
// tb_qspi_slave: host-port vector table plus SPI command sequences with a
// byte scoreboard for everything the slave streams back.
`timescale 1ns/1ps
module tb_qspi_slave;

  logic        clk = 1'b0;
  logic        rst_n, write, sclk, cs_n;
  logic [3:0]  be, io_in, io_out, io_oe;
  logic [7:0]  addr;
  logic [31:0] wdata, rdata;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];

  typedef struct {
    bit          we;
    logic [7:0]  waddr;
    logic [3:0]  wbe;
    logic [31:0] wdata;
    logic [7:0]  raddr;
    logic [3:0]  rbe;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [9];

  always #5 clk = ~clk;

  qspi_slave #(.MEM_BYTES(64), .JEDEC_ID(24'h010219), .SYNC_STAGES(2)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .write_i   (write),
    .data_be_i (be),
    .addr_i    (addr),
    .wdata_i   (wdata),
    .rdata_o   (rdata),
    .sclk_i    (sclk),
    .cs_ni     (cs_n),
    .io_i      (io_in),
    .io_o      (io_out),
    .io_oe     (io_oe)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: got still running, expected finished");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One sclk period: drive while low, sample slave output just before rising
  task automatic xfer(input logic [3:0] dout, output logic [3:0] din, output logic [3:0] oe);
    io_in = dout;
    repeat (6) @(posedge clk);
    #1;
    din  = io_out;
    oe   = io_oe;
    sclk = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    sclk = 1'b0;
  endtask

  task automatic send_bits(input logic [7:0] v, input int n);
    logic [3:0] d, o;
    for (int i = 0; i < n; i++) xfer({3'b000, v[7-i]}, d, o);
  endtask

  task automatic send_addr(input logic [23:0] a);
    send_bits(a[23:16], 8);
    send_bits(a[15:8], 8);
    send_bits(a[7:0], 8);
  endtask

  task automatic recv_byte(input bit quad, output logic [7:0] b,
                           output logic [3:0] oe_or, output logic [3:0] oe_and);
    logic [3:0] d, o;
    b = '0; oe_or = '0; oe_and = 4'hF;
    for (int i = 0; i < (quad ? 2 : 8); i++) begin
      xfer(4'h0, d, o);
      b = quad ? {b[3:0], d} : {b[6:0], d[1]};
      oe_or  = oe_or | o;
      oe_and = oe_and & o;
    end
  endtask

  // Pop one expected byte per received byte and compare data and drive enables
  task automatic sb_read(input int n, input bit quad, input logic [3:0] exp_oe, input string name);
    logic [7:0] b, e;
    logic [3:0] oor, oand;
    for (int i = 0; i < n; i++) begin
      recv_byte(quad, b, oor, oand);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s byte%0d: got %h, expected a queued byte (queue empty)", name, i, b);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("%s byte%0d", name, i), {24'h0, b}, {24'h0, e});
      end
      check($sformatf("%s oe%0d", name, i), {24'h0, oor, oand}, {24'h0, exp_oe, exp_oe});
    end
  endtask

  task automatic cs_begin();
    cs_n  = 1'b0;
    io_in = 4'h0;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic cs_end();
    repeat (2) @(posedge clk);
    #1;
    cs_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic simple_cmd(input logic [7:0] op);
    cs_begin();
    send_bits(op, 8);
    cs_end();
  endtask

  task automatic host_check(input logic [7:0] a, input logic [3:0] b, input logic [31:0] exp, input string name);
    addr = a;
    be   = b;
    #1;
    check(name, rdata, exp);
  endtask

  task automatic rdsr(input logic [7:0] exp, input string name);
    cs_begin();
    send_bits(8'h05, 8);
    exp_q.push_back(exp);
    sb_read(1, 1'b0, 4'b0010, name);
    cs_end();
  endtask

  initial begin
    logic [7:0] b;
    logic [3:0] d, o, oacc;

    vecs[0] = '{1'b1, 8'h10, 4'hF, 32'hFF003CA5, 8'h10, 4'hF, 32'hFF003CA5};
    vecs[1] = '{1'b1, 8'h20, 4'h1, 32'h000000EE, 8'h20, 4'h1, 32'h000000EE};
    vecs[2] = '{1'b1, 8'h3F, 4'h1, 32'h00000077, 8'h3F, 4'h1, 32'h00000077};
    vecs[3] = '{1'b1, 8'h00, 4'h1, 32'h00000066, 8'h00, 4'h1, 32'h00000066};
    vecs[4] = '{1'b0, 8'h00, 4'h0, 32'h00000000, 8'h3F, 4'h3, 32'h00006677};
    vecs[5] = '{1'b0, 8'h00, 4'h0, 32'h00000000, 8'h7F, 4'h3, 32'h00006677};
    vecs[6] = '{1'b0, 8'h00, 4'h0, 32'h00000000, 8'h10, 4'hA, 32'hFF003C00};
    vecs[7] = '{1'b0, 8'h00, 4'h0, 32'h00000000, 8'h10, 4'h0, 32'h00000000};
    vecs[8] = '{1'b1, 8'h2F, 4'h6, 32'h00CCDD00, 8'h30, 4'h3, 32'h0000CCDD};

    rst_n = 1'b0; cs_n = 1'b1; sclk = 1'b0; io_in = 4'h0;
    write = 1'b0; be = 4'h0; addr = 8'h00; wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset io_oe", {28'h0, io_oe}, 32'h0);
    check("reset io_o", {28'h0, io_out}, 32'h0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Host register port vectors
    for (int i = 0; i < 9; i++) begin
      if (vecs[i].we) begin
        addr = vecs[i].waddr; be = vecs[i].wbe; wdata = vecs[i].wdata; write = 1'b1;
        @(posedge clk);
        #1;
        write = 1'b0;
      end
      host_check(vecs[i].raddr, vecs[i].rbe, vecs[i].exp, $sformatf("host vec%0d", i));
    end

    // READ from 0x10
    cs_begin();
    send_bits(8'h03, 8);
    send_addr(24'h000010);
    exp_q.push_back(8'hA5); exp_q.push_back(8'h3C);
    exp_q.push_back(8'h00); exp_q.push_back(8'hFF);
    sb_read(4, 1'b0, 4'b0010, "read");
    cs_end();

    // PP without WEL is dropped, with WREN it lands and clears WEL
    cs_begin(); send_bits(8'h02, 8); send_addr(24'h000020); send_bits(8'h55, 8); cs_end();
    host_check(8'h20, 4'h1, 32'h000000EE, "pp gated");
    simple_cmd(8'h06);
    rdsr(8'h02, "rdsr wel");
    cs_begin(); send_bits(8'h02, 8); send_addr(24'h000020); send_bits(8'h55, 8); cs_end();
    host_check(8'h20, 4'h1, 32'h00000055, "pp write");
    rdsr(8'h00, "rdsr after pp");

    // PP wrapping past the top of the buffer
    simple_cmd(8'h06);
    cs_begin(); send_bits(8'h02, 8); send_addr(24'h00003F);
    send_bits(8'h11, 8); send_bits(8'h22, 8); cs_end();
    host_check(8'h3F, 4'h3, 32'h00002211, "pp wrap");

    // SPI commit collides with a host write to the same byte
    simple_cmd(8'h06);
    cs_begin(); send_bits(8'h02, 8); send_addr(24'h000008); send_bits(8'h5A, 7);
    io_in = 4'h0;
    repeat (6) @(posedge clk);
    #1;
    sclk = 1'b1; addr = 8'h08; be = 4'h3; wdata = 32'h0000C3F0; write = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    write = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    sclk = 1'b0;
    cs_end();
    host_check(8'h08, 4'h3, 32'h0000C35A, "collision");

    // RDID repeats the three ID bytes
    cs_begin();
    send_bits(8'h9F, 8);
    for (int r = 0; r < 2; r++) begin
      exp_q.push_back(8'h01); exp_q.push_back(8'h02); exp_q.push_back(8'h19);
    end
    sb_read(6, 1'b0, 4'b0010, "rdid");
    cs_end();

    // Chip-select abort in the middle of a read
    cs_begin(); send_bits(8'h03, 8); send_addr(24'h000010);
    exp_q.push_back(8'hA5);
    sb_read(1, 1'b0, 4'b0010, "abort read");
    check("abort oe before", {28'h0, io_oe}, 32'h2);
    cs_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("abort oe after", {28'h0, io_oe}, 32'h0);
    repeat (6) @(posedge clk);
    #1;

    // Partial PP data byte is discarded
    simple_cmd(8'h06);
    cs_begin(); send_bits(8'h02, 8); send_addr(24'h000020); send_bits(8'hAA, 5); cs_end();
    host_check(8'h20, 4'h1, 32'h00000055, "partial byte");
    rdsr(8'h00, "rdsr after abort");

    // Reset in the middle of a read
    cs_begin(); send_bits(8'h03, 8); send_addr(24'h000010);
    exp_q.push_back(8'hA5);
    sb_read(1, 1'b0, 4'b0010, "rst read");
    rst_n = 1'b0; cs_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst oe", {28'h0, io_oe}, 32'h0);
    check("rst io_o", {28'h0, io_out}, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    cs_begin(); send_bits(8'h03, 8); send_addr(24'h000012);
    exp_q.push_back(8'h00); exp_q.push_back(8'hFF);
    sb_read(2, 1'b0, 4'b0010, "read after rst");
    cs_end();
    host_check(8'h10, 4'hF, 32'hFF003CA5, "buffer kept");

`ifdef QSPI_SLAVE_QUAD_EN
    cs_begin(); send_bits(8'h6B, 8); send_addr(24'h000010);
    oacc = '0;
    for (int i = 0; i < 8; i++) begin
      xfer(4'h0, d, o);
      oacc = oacc | o;
    end
    check("qor dummy oe", {28'h0, oacc}, 32'h0);
    exp_q.push_back(8'hA5); exp_q.push_back(8'h3C);
    sb_read(2, 1'b1, 4'hF, "qor");
    cs_end();
`else
    cs_begin(); send_bits(8'h6B, 8); send_addr(24'h000010);
    oacc = '0;
    for (int i = 0; i < 12; i++) begin
      xfer(4'h0, d, o);
      oacc = oacc | o;
    end
    check("qor disabled oe", {28'h0, oacc}, 32'h0);
    cs_end();
`endif

    check("scoreboard drained", exp_q.size(), 32'd0);
    b = 8'h00;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
